fpu_wb_arbiter: RTL and testbench

Parametrised writeback merger for the FPU: collects results from N_CH independent execution units (add, mult, i2f, f2i, fcmp, div, ...) and serialises them onto the single FPU result port. It replaces the fixed-channel, single-entry merge with per-channel FIFOs, a selectable arbitration policy, per-channel back-pressure and stall support from the register-file write port. It sits between the FPU sub-units and the writeback stage.

---
 rtl/fpu_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_fpu_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_arbiter.sv
// FPU writeback merger: per-channel result FIFOs feeding one result port.
// Arbitration is fixed-priority (MODE 0) or round-robin (MODE 1). A stall
// from the register-file write port freezes the output register and all pops.
//
// Handshake: a producer's result is accepted at a rising edge when
// in_valid[i] && in_ready[i]. in_ready depends only on registered occupancy.
// A result presented while in_ready[i] is low is dropped and sets the sticky
// overflow[i] flag. On the output side, out_valid/out_* are registered and
// held unchanged while out_stall is high; the next result loads on the first
// edge with out_stall low.
module fpu_wb_arbiter #(
    parameter int N_CH   = 6,
    parameter int DEPTH  = 4,
    parameter int AFULL  = 3,
    parameter int WIDTH  = 32,
    parameter int DEST_W = 5,
    parameter int MODE   = 1,
    localparam int CH_W  = $clog2(N_CH),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DEST_W-1:0]   in_dest,
    input  logic [N_CH*WIDTH-1:0]    in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic [N_CH-1:0]          ch_busy,
    output logic [N_CH-1:0]          overflow,
    input  logic                     out_stall,
    output logic                     out_valid,
    output logic [DEST_W-1:0]        out_dest,
    output logic [WIDTH-1:0]         out_data,
    output logic [CH_W-1:0]          out_channel
);

    // FIFO storage (not reset: occupancy counters decide what is live)
    logic [DEST_W-1:0] r_mem_dest [N_CH][DEPTH];
    logic [WIDTH-1:0]  r_mem_data [N_CH][DEPTH];

    logic [CNT_W-1:0]  r_count  [N_CH];
    logic [PTR_W-1:0]  r_wr_ptr [N_CH];
    logic [PTR_W-1:0]  r_rd_ptr [N_CH];
    logic [CH_W-1:0]   r_rr_ptr;
    logic [N_CH-1:0]   r_overflow;

    logic [N_CH-1:0]   w_cand;
    logic [N_CH-1:0]   w_push;
    logic [N_CH-1:0]   w_pop;
    logic              w_grant_valid;
    logic [CH_W-1:0]   w_grant_idx;
    logic [DEST_W-1:0] w_head_dest;
    logic [WIDTH-1:0]  w_head_data;

    // Per-channel status derived from registered occupancy only
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = (r_count[i] != CNT_W'(DEPTH));
            ch_busy[i]  = (r_count[i] >= CNT_W'(AFULL));
            w_cand[i]   = (r_count[i] != '0);
            w_push[i]   = in_valid[i] && in_ready[i];
            w_pop[i]    = !out_stall && w_grant_valid && (w_grant_idx == CH_W'(i));
        end
    end

    assign overflow = r_overflow;

    // Grant selection; descending scans leave the winning (first) match last
    always_comb begin
        int j;
        j             = 0;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        if (MODE == 0) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (w_cand[i]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = CH_W'(i);
                end
            end
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                j = int'(r_rr_ptr) + k;
                if (j >= N_CH) j = j - N_CH;
                if (w_cand[j]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = CH_W'(j);
                end
            end
        end
    end

    // Head entry of the granted channel
    always_comb begin
        w_head_dest = r_mem_dest[w_grant_idx][r_rd_ptr[w_grant_idx]];
        w_head_data = r_mem_data[w_grant_idx][r_rd_ptr[w_grant_idx]];
    end

    // FIFO payload writes
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_CH; i++) begin
            if (w_push[i]) begin
                r_mem_dest[i][r_wr_ptr[i]] <= in_dest[i*DEST_W +: DEST_W];
                r_mem_data[i][r_wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_count[i]  <= '0;
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                if (in_valid[i] && !in_ready[i]) r_overflow[i] <= 1'b1;
            end
        end
    end

    // Output register and round-robin pointer; both frozen while stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_dest    <= '0;
            out_data    <= '0;
            out_channel <= '0;
            r_rr_ptr    <= '0;
        end else if (!out_stall) begin
            out_valid <= w_grant_valid;
            if (w_grant_valid) begin
                out_dest    <= w_head_dest;
                out_data    <= w_head_data;
                out_channel <= w_grant_idx;
                if (w_grant_idx == CH_W'(N_CH - 1)) r_rr_ptr <= '0;
                else                                r_rr_ptr <= w_grant_idx + CH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed bench for fpu_wb_arbiter: one round-robin and one fixed-priority
// instance, four channels each, sharing clock, reset and stall.
module tb_fpu_wb_arbiter;

    localparam int NC = 4;
    localparam int W  = 32;
    localparam int DW = 5;

    logic            clock;
    logic            reset_n;
    logic            out_stall;

    logic [NC-1:0]    a_valid, b_valid;
    logic [NC*DW-1:0] a_dest,  b_dest;
    logic [NC*W-1:0]  a_data,  b_data;
    logic [NC-1:0]    a_ready, b_ready, a_busy, b_busy, a_ovf, b_ovf;
    logic             a_ovalid, b_ovalid;
    logic [DW-1:0]    a_odest, b_odest;
    logic [W-1:0]     a_odata, b_odata;
    logic [1:0]       a_ochan, b_ochan;

    int checks = 0;
    int errors = 0;

    fpu_wb_arbiter #(.N_CH(NC), .DEPTH(4), .AFULL(3), .WIDTH(W), .DEST_W(DW), .MODE(1)) u_rr (
        .clock(clock), .reset_n(reset_n),
        .in_valid(a_valid), .in_dest(a_dest), .in_data(a_data),
        .in_ready(a_ready), .ch_busy(a_busy), .overflow(a_ovf),
        .out_stall(out_stall), .out_valid(a_ovalid), .out_dest(a_odest),
        .out_data(a_odata), .out_channel(a_ochan)
    );

    fpu_wb_arbiter #(.N_CH(NC), .DEPTH(4), .AFULL(3), .WIDTH(W), .DEST_W(DW), .MODE(0)) u_fp (
        .clock(clock), .reset_n(reset_n),
        .in_valid(b_valid), .in_dest(b_dest), .in_data(b_data),
        .in_ready(b_ready), .ch_busy(b_busy), .overflow(b_ovf),
        .out_stall(out_stall), .out_valid(b_ovalid), .out_dest(b_odest),
        .out_data(b_odata), .out_channel(b_ochan)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input int ch, input logic [DW-1:0] d, input logic [W-1:0] v);
        a_valid[ch]        = 1'b1;
        a_dest[ch*DW +: DW] = d;
        a_data[ch*W +: W]   = v;
    endtask

    task automatic drive_b(input int ch, input logic [DW-1:0] d, input logic [W-1:0] v);
        b_valid[ch]        = 1'b1;
        b_dest[ch*DW +: DW] = d;
        b_data[ch*W +: W]   = v;
    endtask

    task automatic expect_a(input string tag, input int ch, input logic [DW-1:0] d, input logic [W-1:0] v);
        check({tag, "_valid"}, a_ovalid, 1);
        check({tag, "_chan"},  a_ochan, ch);
        check({tag, "_dest"},  a_odest, d);
        check({tag, "_data"},  a_odata, v);
    endtask

    initial begin
        reset_n   = 1'b0;
        out_stall = 1'b0;
        a_valid = '0; a_dest = '0; a_data = '0;
        b_valid = '0; b_dest = '0; b_data = '0;
        tick();
        tick();

        // reset state
        check("rst_ovalid", a_ovalid, 0);
        check("rst_ready",  a_ready, 4'hF);
        check("rst_busy",   a_busy, 0);
        check("rst_ovf",    a_ovf, 0);
        check("rst_b_ready", b_ready, 4'hF);
        reset_n = 1'b1;
        tick();

        // round robin: all four channels at once
        for (int i = 0; i < NC; i++) drive_a(i, DW'(i + 1), 32'hA0 + i);
        tick();
        a_valid = '0;
        check("rr_lat", a_ovalid, 0);
        for (int i = 0; i < NC; i++) begin
            tick();
            expect_a($sformatf("rr_all%0d", i), i, DW'(i + 1), 32'hA0 + i);
        end
        tick();
        check("rr_idle", a_ovalid, 0);

        // round robin with rr_ptr = 0: push 1,3; pop 1 while pushing 0,3
        drive_a(1, 5'd11, 32'hB1);
        drive_a(3, 5'd13, 32'hB3);
        tick();
        a_valid = '0;
        drive_a(0, 5'd10, 32'hC0);
        drive_a(3, 5'd14, 32'hC3);
        tick();
        a_valid = '0;
        expect_a("rr_mix0", 1, 5'd11, 32'hB1);
        tick();
        expect_a("rr_mix1", 3, 5'd13, 32'hB3);
        tick();
        expect_a("rr_mix2", 0, 5'd10, 32'hC0);
        tick();
        expect_a("rr_mix3", 3, 5'd14, 32'hC3);
        tick();
        check("rr_mix_idle", a_ovalid, 0);

        // single result on the fixed-priority instance
        drive_b(2, 5'd7, 32'h3F800000);
        tick();
        b_valid = '0;
        check("single_c1_valid", b_ovalid, 0);
        tick();
        check("single_c2_valid", b_ovalid, 1);
        check("single_c2_dest",  b_odest, 7);
        check("single_c2_data",  b_odata, 32'h3F800000);
        check("single_c2_chan",  b_ochan, 2);
        tick();
        check("single_c3_valid", b_ovalid, 0);

        // fixed priority: ch0 streams for 6 cycles, ch3 waits until cycle 8
        for (int c = 0; c < 9; c++) begin
            b_valid = '0;
            if (c < 6)  drive_b(0, DW'(c), 32'h100 + c);
            if (c == 0) drive_b(3, 5'd30, 32'h333);
            tick();
            if ((c + 1) >= 2 && (c + 1) <= 7) begin
                check($sformatf("fp_c%0d_chan", c + 1), b_ochan, 0);
                check($sformatf("fp_c%0d_data", c + 1), b_odata, 32'h100 + (c - 1));
                check($sformatf("fp_c%0d_valid", c + 1), b_ovalid, 1);
            end else if ((c + 1) == 8) begin
                check("fp_c8_valid", b_ovalid, 1);
                check("fp_c8_chan",  b_ochan, 3);
                check("fp_c8_data",  b_odata, 32'h333);
            end else begin
                check($sformatf("fp_c%0d_idle", c + 1), b_ovalid, 0);
            end
        end
        b_valid = '0;

        // full / overflow on channel 1 with the output stalled
        out_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_valid = '0;
            drive_a(1, DW'(k), 32'hD0 + k);
            tick();
            check($sformatf("full_p%0d_busy", k + 1),  a_busy[1],  (k >= 2));
            check($sformatf("full_p%0d_ready", k + 1), a_ready[1], (k < 3));
            check($sformatf("full_p%0d_ovf", k + 1),   a_ovf[1],   (k == 4));
            check($sformatf("full_p%0d_ovalid", k + 1), a_ovalid, 0);
        end
        a_valid   = '0;
        out_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_a($sformatf("full_out%0d", k), 1, DW'(k), 32'hD0 + k);
            if (k == 0) check("full_ready_back", a_ready[1], 1);
        end
        tick();
        check("full_drained", a_ovalid, 0);
        check("full_ovf_sticky", a_ovf[1], 1);

        // stall hold with a valid result on the port
        drive_a(2, 5'd20, 32'hE0);
        tick();
        a_valid = '0;
        drive_a(2, 5'd21, 32'hE1);
        tick();
        a_valid = '0;
        expect_a("stall_pre", 2, 5'd20, 32'hE0);
        out_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_a($sformatf("stall_hold%0d", k), 2, 5'd20, 32'hE0);
        end
        out_stall = 1'b0;
        tick();
        expect_a("stall_next", 2, 5'd21, 32'hE1);
        tick();
        check("stall_idle_valid", a_ovalid, 0);
        check("stall_idle_hold",  a_odata, 32'hE1);

        // asynchronous reset with entries queued and a result on the port
        out_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_valid = '0;
            drive_a(0, DW'(k), 32'hF0 + k);
            tick();
        end
        a_valid   = '0;
        out_stall = 1'b0;
        tick();
        out_stall = 1'b1;
        check("prerst_ovalid", a_ovalid, 1);
        check("prerst_busy0",  a_busy[0], 1);
        check("prerst_ovf1",   a_ovf[1], 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ovalid", a_ovalid, 0);
        check("arst_ovf",    a_ovf, 0);
        check("arst_ready",  a_ready, 4'hF);
        check("arst_busy",   a_busy, 0);
        check("arst_odata",  a_odata, 0);
        tick();
        reset_n   = 1'b1;
        out_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("postrst_idle%0d", k), a_ovalid, 0);
        end
        check("postrst_ready", a_ready, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
